// File: rtl/ones_pkg.sv
// ones_pkg: shared FSM states, defaults and the clamped thermometer reference function
package ones_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int FRAME_LEN_DEFAULT = 3;
    function automatic logic [31:0] thermo_of(input int unsigned count, input int unsigned frame_len);
        int unsigned n;
        n = (count > frame_len) ? frame_len : count;
        return (n >= 32) ? '1 : (32'd1 << n) - 32'd1;
    endfunction
endpackage

// File: rtl/ones_frame_shifter.sv
// ones_frame_shifter: loadable down-counting bit index with MSB-first serial select
module ones_frame_shifter #(
    parameter int FRAME_LEN = 3,
    parameter int IW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 active,
    input  logic [FRAME_LEN-1:0] thermo,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 frame_done
);
    logic [IW-1:0] idx;
    always_ff @(posedge clk) begin
        if (rst) idx <= '0;
        else if (load) idx <= IW'(FRAME_LEN - 1);
        else if (active && idx != '0) idx <= idx - IW'(1);
    end
    assign sout_valid = active;
    assign sout = active & thermo[idx];
    assign frame_done = active && idx == '0;
endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: regenerates a thermometer pattern from a ones count and shifts it out MSB-first
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     count,
    output logic                 ready,
    output logic [FRAME_LEN-1:0] thermo,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 frame_done,
    output logic                 err
);
    localparam int IW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    state_t state, state_nx;
    logic accept, over;
    logic [CNT_W:0] cnt_c;
    always_comb begin
        accept = state == IDLE && start;
        over = {1'b0, count} > (CNT_W+1)'(FRAME_LEN);
        cnt_c = over ? (CNT_W+1)'(FRAME_LEN) : {1'b0, count};
        state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (frame_done ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            thermo <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            err <= accept && over;
            if (accept) thermo <= FRAME_LEN'(thermo_of(32'(cnt_c), FRAME_LEN));
        end
    end
    assign ready = state == IDLE;
    ones_frame_shifter #(.FRAME_LEN(FRAME_LEN), .IW(IW)) u_shift (
        .clk(clk),
        .rst(rst),
        .load(accept),
        .active(state == SHIFT),
        .thermo(thermo),
        .sout(sout),
        .sout_valid(sout_valid),
        .frame_done(frame_done)
    );
endmodule
